// File: rtl/bulk_read_arbiter_if.sv
// Whole-line memory port shared by the caches and the downstream memory.
// The request carries a full line of write data with a byte strobe. The
// response returns a full line.
interface bulk_read_interface #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int WORDS_PER_LINE = 16
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int STRB_W = LINE_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [STRB_W-1:0] req_wstrb;
  logic [LINE_W-1:0] req_wdata;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_rdata;
  logic              dumping_cache;

  modport slave (
    input  req_valid, req_write, req_addr, req_wstrb, req_wdata, dumping_cache,
    output req_ready, resp_valid, resp_rdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wstrb, req_wdata, dumping_cache,
    input  req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bulk_read_arbiter.sv
// Round-robin arbiter that shares one bulk line port between two caches.
// A grant is held until the downstream handshake. A read also holds the
// port until its line returns. A cache that is dumping keeps the port
// locked to itself so that its writebacks stay contiguous.
module bulk_read_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int WORDS_PER_LINE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  bulk_read_interface.slave       s0,
  bulk_read_interface.slave       s1,
  bulk_read_interface.master      m,
  output logic                    owner,
  output logic                    busy,
  output logic                    proto_err
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int STRB_W = LINE_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_HOLD      = 2'd1,
    ARB_WAIT_RESP = 2'd2
  } arb_state_t;

  arb_state_t        state_r;
  arb_state_t        state_next_s;
  logic              last_grant_r;
  logic              hold_port_r;
  logic              rd_owner_r;
  logic              lock_r;
  logic              lock_owner_r;
  logic              owner_r;
  logic              busy_r;
  logic              proto_err_r;

  logic              win_s;
  logic              win_valid_s;
  logic              lock_dump_s;
  logic              gport_s;
  logic              fwd_s;
  logic              sel_valid_s;
  logic              sel_write_s;
  logic              sel_dump_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [STRB_W-1:0] sel_wstrb_s;
  logic [LINE_W-1:0] sel_wdata_s;
  logic              m_valid_s;
  logic              hs_s;

  // Pick the idle-state winner: the dump lock wins first, then a lone requester, then round-robin.
  always_comb begin
    win_s       = 1'b0;
    win_valid_s = 1'b0;
    lock_dump_s = lock_owner_r ? s1.dumping_cache : s0.dumping_cache;
    if (lock_r) begin
      win_s       = lock_owner_r;
      win_valid_s = lock_owner_r ? s1.req_valid : s0.req_valid;
    end else if (s0.req_valid && s1.req_valid) begin
      win_s       = ~last_grant_r;
      win_valid_s = 1'b1;
    end else if (s0.req_valid) begin
      win_s       = 1'b0;
      win_valid_s = 1'b1;
    end else if (s1.req_valid) begin
      win_s       = 1'b1;
      win_valid_s = 1'b1;
    end else begin
      win_s       = 1'b0;
      win_valid_s = 1'b0;
    end
  end

  // Decide which port is forwarded this cycle, if any.
  always_comb begin
    gport_s = 1'b0;
    fwd_s   = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        gport_s = win_s;
        fwd_s   = win_valid_s;
      end
      ARB_HOLD: begin
        gport_s = hold_port_r;
        fwd_s   = 1'b1;
      end
      ARB_WAIT_RESP: begin
        gport_s = 1'b0;
        fwd_s   = 1'b0;
      end
      default: begin
        gport_s = 1'b0;
        fwd_s   = 1'b0;
      end
    endcase
  end

  // Mux the forwarded port's request fields.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_write_s = 1'b0;
    sel_dump_s  = 1'b0;
    sel_addr_s  = '0;
    sel_wstrb_s = '0;
    sel_wdata_s = '0;
    if (gport_s) begin
      sel_valid_s = s1.req_valid;
      sel_write_s = s1.req_write;
      sel_dump_s  = s1.dumping_cache;
      sel_addr_s  = s1.req_addr;
      sel_wstrb_s = s1.req_wstrb;
      sel_wdata_s = s1.req_wdata;
    end else begin
      sel_valid_s = s0.req_valid;
      sel_write_s = s0.req_write;
      sel_dump_s  = s0.dumping_cache;
      sel_addr_s  = s0.req_addr;
      sel_wstrb_s = s0.req_wstrb;
      sel_wdata_s = s0.req_wdata;
    end
    m_valid_s = fwd_s & sel_valid_s;
    hs_s      = m_valid_s & m.req_ready;
  end

  // Drive the downstream request, and steer ready and response back to the owning port.
  always_comb begin
    m.req_valid     = m_valid_s;
    m.req_write     = fwd_s ? sel_write_s : 1'b0;
    m.req_addr      = fwd_s ? sel_addr_s  : '0;
    m.req_wstrb     = fwd_s ? sel_wstrb_s : '0;
    m.req_wdata     = fwd_s ? sel_wdata_s : '0;
    m.dumping_cache = s0.dumping_cache | s1.dumping_cache;
    s0.req_ready    = (fwd_s && !gport_s) ? m.req_ready : 1'b0;
    s1.req_ready    = (fwd_s &&  gport_s) ? m.req_ready : 1'b0;
    s0.resp_valid   = (state_r == ARB_WAIT_RESP && !rd_owner_r) ? m.resp_valid : 1'b0;
    s1.resp_valid   = (state_r == ARB_WAIT_RESP &&  rd_owner_r) ? m.resp_valid : 1'b0;
    s0.resp_rdata   = m.resp_rdata;
    s1.resp_rdata   = m.resp_rdata;
  end

  // Compute the next arbitration state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (win_valid_s) begin
          if (hs_s) begin
            state_next_s = sel_write_s ? ARB_IDLE : ARB_WAIT_RESP;
          end else begin
            state_next_s = ARB_HOLD;
          end
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_HOLD: begin
        if (hs_s) begin
          state_next_s = sel_write_s ? ARB_IDLE : ARB_WAIT_RESP;
        end else if (!sel_valid_s) begin
          state_next_s = ARB_IDLE;
        end else begin
          state_next_s = ARB_HOLD;
        end
      end
      ARB_WAIT_RESP: begin
        if (m.resp_valid) begin
          state_next_s = ARB_IDLE;
        end else begin
          state_next_s = ARB_WAIT_RESP;
        end
      end
      default: begin
        state_next_s = ARB_IDLE;
      end
    endcase
  end

  // Register the state, the grant history, the dump lock and the status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= 1'b1;
      hold_port_r  <= 1'b0;
      rd_owner_r   <= 1'b0;
      lock_r       <= 1'b0;
      lock_owner_r <= 1'b0;
      owner_r      <= 1'b0;
      busy_r       <= 1'b0;
      proto_err_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ARB_IDLE);
      if (hs_s) begin
        last_grant_r <= gport_s;
        if (!sel_write_s) begin
          rd_owner_r <= gport_s;
        end
      end
      if (state_r == ARB_IDLE && win_valid_s) begin
        hold_port_r <= win_s;
        owner_r     <= win_s;
      end
      if (state_r == ARB_IDLE && win_valid_s && sel_dump_s) begin
        lock_r       <= 1'b1;
        lock_owner_r <= win_s;
      end else if (state_r == ARB_IDLE && lock_r && !lock_dump_s) begin
        lock_r <= 1'b0;
      end
      if (m.resp_valid && state_r != ARB_WAIT_RESP) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign owner     = owner_r;
  assign busy      = busy_r;
  assign proto_err = proto_err_r;
endmodule

// File: tb/tb_bulk_read_arbiter.sv
// Self-checking bench for bulk_read_arbiter. It uses a transaction-level
// model of who holds the port, who awaits a line, the last grant and the
// dump lock. A few directed steps carry literal expectations, and a long
// randomized run follows.
module tb_bulk_read_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPL = 2;
  localparam int LW  = DW * WPL;
  localparam int SW  = LW / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic owner, busy, proto_err;

  bulk_read_interface #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) i0 ();
  bulk_read_interface #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) i1 ();
  bulk_read_interface #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) im ();

  bulk_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst(rst), .s0(i0), .s1(i1), .m(im),
    .owner(owner), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: port holding an un-handshaken grant, port awaiting a line, last grant,
  // lock owner (-1 for none), owner output, sticky protocol error.
  int mb = -1;
  int mw = -1;
  int ml = 1;
  int mk = -1;
  int mo = 0;
  bit mp = 1'b0;

  logic          v [2];
  logic          w [2];
  logic          d [2];
  logic [AW-1:0] a [2];
  logic [SW-1:0] ws[2];
  logic [LW-1:0] wd[2];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input bit v0, input bit v1, input bit w0, input bit w1,
                       input bit d0, input bit d1, input bit mrdy, input bit mresp,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [LW-1:0] rd);
    bit idle, exp_mv, hs;
    int win, fp;
    v[0] = v0; v[1] = v1; w[0] = w0; w[1] = w1; d[0] = d0; d[1] = d1;
    a[0] = a0; a[1] = a1;
    for (int i = 0; i < 2; i++) begin
      ws[i] = SW'($urandom);
      wd[i] = {$urandom, $urandom};
    end
    rst = r;
    i0.req_valid = v0; i0.req_write = w0; i0.dumping_cache = d0;
    i0.req_addr = a0; i0.req_wstrb = ws[0]; i0.req_wdata = wd[0];
    i1.req_valid = v1; i1.req_write = w1; i1.dumping_cache = d1;
    i1.req_addr = a1; i1.req_wstrb = ws[1]; i1.req_wdata = wd[1];
    im.req_ready = mrdy; im.resp_valid = mresp; im.resp_rdata = rd;
    #1;
    if (r) begin
      mb = -1; mw = -1; ml = 1; mk = -1; mo = 0; mp = 1'b0;
    end else begin
      idle = (mb < 0 && mw < 0);
      win  = -1;
      if (idle) begin
        if (mk >= 0) begin
          if (v[mk]) win = mk;
        end else if (v[0] && v[1]) win = 1 - ml;
        else if (v[0]) win = 0;
        else if (v[1]) win = 1;
      end
      fp = idle ? win : ((mw < 0) ? mb : -1);
      exp_mv = 1'b0;
      if (fp >= 0) begin
        exp_mv = v[fp];
        chk("m_addr",  LW'(im.req_addr),  LW'(a[fp]));
        chk("m_write", LW'(im.req_write), LW'(w[fp]));
        chk("m_wstrb", LW'(im.req_wstrb), LW'(ws[fp]));
        chk("m_wdata", im.req_wdata, wd[fp]);
      end else begin
        chk("m_addr_idle",  LW'(im.req_addr),  '0);
        chk("m_write_idle", LW'(im.req_write), '0);
        chk("m_wdata_idle", im.req_wdata, '0);
      end
      chk("m_valid",  LW'(im.req_valid),     LW'(exp_mv));
      chk("m_dump",   LW'(im.dumping_cache), LW'(d0 | d1));
      chk("s0_ready", LW'(i0.req_ready),  LW'(fp == 0 && mrdy));
      chk("s1_ready", LW'(i1.req_ready),  LW'(fp == 1 && mrdy));
      chk("s0_rvld",  LW'(i0.resp_valid), LW'(mw == 0 && mresp));
      chk("s1_rvld",  LW'(i1.resp_valid), LW'(mw == 1 && mresp));
      chk("s0_rdata", i0.resp_rdata, rd);
      chk("s1_rdata", i1.resp_rdata, rd);
      hs = exp_mv && mrdy;
      if (mw >= 0) begin
        if (mresp) mw = -1;
      end else if (mresp) mp = 1'b1;
      if (idle && win >= 0) mo = win;
      if (idle) begin
        if (win >= 0 && d[win]) mk = win;
        else if (mk >= 0 && !d[mk]) mk = -1;
      end
      if (fp >= 0 && hs) begin
        ml = fp;
        mb = -1;
        if (!w[fp]) mw = fp;
      end else if (idle && win >= 0) mb = win;
      else if (mb >= 0 && !v[mb]) mb = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("owner",     LW'(owner),     LW'(mo));
    chk("busy",      LW'(busy),      LW'(mb >= 0 || mw >= 0));
    chk("proto_err", LW'(proto_err), LW'(mp));
  endtask

  localparam logic [LW-1:0] PAT_A = 64'hA5A5_0F0F_1234_5678;

  initial begin
    bit dd0, dd1, rr, rsp;
    dd0 = 1'b0;
    dd1 = 1'b0;
    @(posedge clk);
    #1;
    // Reset for two cycles.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0); tick();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0); tick();
    chk("lit_rst_owner", LW'(owner), '0);
    chk("lit_rst_busy",  LW'(busy),  '0);
    chk("lit_rst_perr",  LW'(proto_err), '0);
    // Both ports read; port 0 wins the first tie and is held while not ready.
    apply(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h1000, 32'h2000, '0);
    chk("lit_tie_addr", LW'(im.req_addr), LW'(32'h1000));
    chk("lit_tie_s0rdy", LW'(i0.req_ready), '0);
    tick();
    chk("lit_hold_busy", LW'(busy), LW'(1'b1));
    chk("lit_hold_owner", LW'(owner), '0);
    apply(0, 1, 1, 0, 0, 0, 0, 1, 0, 32'h1000, 32'h2000, '0);
    chk("lit_hs_s0rdy", LW'(i0.req_ready), LW'(1'b1));
    chk("lit_hs_s1rdy", LW'(i1.req_ready), '0);
    tick();
    // The line returns to port 0 only, and nothing is forwarded in this cycle.
    apply(0, 1, 1, 0, 0, 0, 0, 1, 1, 32'h1000, 32'h2000, PAT_A);
    chk("lit_resp_s0", LW'(i0.resp_valid), LW'(1'b1));
    chk("lit_resp_s1", LW'(i1.resp_valid), '0);
    chk("lit_resp_data", i0.resp_rdata, PAT_A);
    chk("lit_resp_mvld", LW'(im.req_valid), '0);
    tick();
    // Next tie goes to port 1: a write that completes at once.
    apply(0, 1, 1, 0, 1, 0, 0, 1, 0, 32'h1000, 32'h2000, '0);
    chk("lit_rr_addr", LW'(im.req_addr), LW'(32'h2000));
    chk("lit_rr_s1rdy", LW'(i1.req_ready), LW'(1'b1));
    tick();
    chk("lit_rr_owner", LW'(owner), LW'(1'b1));
    chk("lit_rr_busy", LW'(busy), '0);
    // A spurious response while idle sets the sticky error.
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, '0, '0, PAT_A);
    chk("lit_spur_s0", LW'(i0.resp_valid), '0);
    tick();
    chk("lit_spur_perr", LW'(proto_err), LW'(1'b1));
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0, '0); tick();
    chk("lit_spur_sticky", LW'(proto_err), LW'(1'b1));
    // Randomized traffic with occasional resets, dumps and spurious responses.
    for (int n = 0; n < 4000; n++) begin
      rr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) dd0 = ~dd0;
      if ($urandom_range(0, 11) == 0) dd1 = ~dd1;
      rsp = (mw >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      apply(rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            dd0, dd1, 1'($urandom_range(0, 1)), rsp,
            AW'($urandom), AW'($urandom), {$urandom, $urandom});
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
